keypad_scan_decoder: RTL and testbench
======================================

Name: keypad_scan_decoder

Overview:
- Keypad-side partner of the scan clock divider that produces `clk_cut`.
- Drives the keypad rows one-cold at the `clk_cut` rate and samples the columns through a synchronizer.
- On a debounced key press it raises `stop_flag` to freeze the divider and latches the key code.
- It publishes that code when the divider pulses `mostrar_dato`, then re-arms once the divider's hold-off (`enable_input`) ends and the key is released.

Parameters:
- ROWS, 4, number of keypad rows driven.
- COLS, 4, number of keypad columns sampled.
- SYNC_STAGES, 2, flip-flop stages on `col_in` (minimum 2).
- STABLE_SAMPLES, 2, consecutive identical scan samples required to accept a key (minimum 1).

Ports:
- clk  input  1  system clock; `clk_cut` is generated in this same domain.
- reset  input  1  asynchronous, active-high.
- clk_cut  input  1  scan tick from the divider; only its rising edge is used.
- enable_input  input  1  high = scanning allowed; low = divider hold-off.
- mostrar_dato  input  1  one-cycle pulse; publish the latched code.
- reset_input_ff  input  1  one-cycle pulse; clear the capture path.
- col_in  input  COLS  keypad columns, active-low, externally pulled up, asynchronous.
- row_out  output  ROWS  row drive, active-low, exactly one bit low.
- stop_flag  output  1  one-cycle pulse; key accepted.
- key_code  output  $clog2(ROWS*COLS)  last published key, equal to row*COLS+col.
- key_valid  output  1  one-cycle pulse when `key_code` updates.

Behaviour:
- Reset clock and polarity:
  - Reset is asynchronous and active-high.
  - All state is on `posedge clk or posedge reset`.
- Reset values:
  - Outputs: `row_out`={1…1,0} (row 0 driven), `stop_flag`=0, `key_code`=0, `key_valid`=0.
  - Internal: state=SCAN, row index=0, match count=0, synchronizer all 1s.
- Tick detection:
  - `clk_cut` is registered; `tick` = `clk_cut` & ~`clk_cut_q`.
  - All sampling and row changes happen only on `tick` cycles.
- Column synchronizer:
  - `col_s` is `col_in` after SYNC_STAGES flops.
  - A column is active when `col_s[c]`==0.
  - If several columns are active, the lowest index wins.
- Enable gating: when `enable_input`==0 in SCAN or CONFIRM, ticks are ignored and state, row and count freeze.
- FSM:
  - SCAN:
    - On `tick`, if no column is active, the row index advances modulo ROWS.
    - `row_out` updates in the cycle after `tick`.
    - If a column is active, record (row, col), set count=1 and go to CONFIRM with the row held.
    - If STABLE_SAMPLES==1, go directly to ACCEPT.
  - CONFIRM:
    - On `tick`, if the same column is still active, count++.
    - When count reaches STABLE_SAMPLES, go to ACCEPT.
    - If a different column or no column is active, clear count, advance the row and return to SCAN.
  - ACCEPT:
    - Single cycle.
    - `stop_flag`=1 for exactly that cycle.
    - Latched code = row*COLS+col.
    - Go to HOLD.
  - HOLD:
    - Row held; `tick` ignored.
    - On `mostrar_dato`: `key_code` <= latched code and `key_valid`=1 for one cycle in the same registered update.
    - If `reset_input_ff` arrives in the same cycle, it clears the latched code, count and synchronizer in that cycle.
    - Nonblocking semantics guarantee the published value is the pre-clear code.
    - Go to RELEASE.
  - RELEASE:
    - Wait for `enable_input`==1.
    - Then, on a `tick` with all columns inactive, set row index=0 and go to SCAN.
    - A held key never produces a second code.
- Boundary conditions:
  - `mostrar_dato` outside HOLD: ignored; `key_code` unchanged, no `key_valid`.
  - `reset_input_ff` outside HOLD: clears only the synchronizer and count; the state is kept.
  - `stop_flag` is never asserted twice without an intervening `mostrar_dato`.
  - `key_code` holds its value until the next publish; it is unaffected by `reset_input_ff`.
  - Row index wraps from ROWS-1 to 0.
  - Reset mid-operation returns everything to reset values immediately (asynchronously), including mid-HOLD; no `key_valid` is generated.
- Latency (with `col_in` stable ≥ SYNC_STAGES clk before the sampling edge): `stop_flag` occurs 1 clk after the `tick` that completes STABLE_SAMPLES.

Test Plan:
- Idle scan, no key pressed, 12 ticks → `row_out` cycles 1110, 1101, 1011, 0111 three times; `stop_flag` never asserted.
- Hold `col_in`=1101 only while row 2 is driven; after 2 ticks, pulse `mostrar_dato` and `reset_input_ff` together → one `stop_flag` pulse, `key_code`=9, one `key_valid`, `row_out` held at 1011 until publish.
- Bounce: `col_in` low on one tick, high on the next (STABLE_SAMPLES=2) → no `stop_flag`; scan resumes with the next row.
- Key held through publish and through `enable_input` returning high → no second `stop_flag` until `col_in`=1111 on a tick; a new press then decodes normally.
- Columns 0 and 3 both active on row 1 → `key_code`=4.
- Assert `reset` during HOLD → `stop_flag`=0, `key_valid`=0, `key_code`=0, `row_out`=1110 immediately; a subsequent `mostrar_dato` yields no `key_valid`.

Source files
------------

// File: rtl/keypad_scan_decoder_if.sv
// Keypad scan bus between the scan clock divider/keypad side and the decoder.
interface keypad_scan_decoder_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  logic            clk_cut;
  logic            enable_input;
  logic            mostrar_dato;
  logic            reset_input_ff;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic            stop_flag;
  logic [KW-1:0]   key_code;
  logic            key_valid;

  modport master (
    output clk_cut, enable_input, mostrar_dato, reset_input_ff, col_in,
    input  row_out, stop_flag, key_code, key_valid
  );

  modport slave (
    input  clk_cut, enable_input, mostrar_dato, reset_input_ff, col_in,
    output row_out, stop_flag, key_code, key_valid
  );
endinterface

// File: rtl/keypad_scan_decoder.sv
// One-cold row scanner with synchronized, debounced column decode; freezes the
// divider on a key, publishes on mostrar_dato and re-arms after key release.
module keypad_scan_decoder #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_SAMPLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_scan_decoder_if.slave  kb
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int NW = $clog2(STABLE_SAMPLES + 1);

  typedef enum logic [2:0] {SCAN, CONFIRM, ACCEPT, HOLD, RELEASE} state_t;

  state_t                          state_q, state_d;
  logic [RW-1:0]                   row_idx_q, row_idx_d;
  logic [RW-1:0]                   rec_row_q, rec_row_d;
  logic [CW-1:0]                   rec_col_q, rec_col_d;
  logic [NW-1:0]                   cnt_q, cnt_d;
  logic [KW-1:0]                   code_q, code_d;
  logic [KW-1:0]                   key_code_q, key_code_d;
  logic [SYNC_STAGES-1:0][COLS-1:0] sync_q, sync_d;
  logic [ROWS-1:0]                 row_out_q, row_out_d;
  logic                            stop_q, stop_d;
  logic                            valid_q, valid_d;
  logic                            clk_cut_q, clk_cut_d;

  logic            tick;
  logic [COLS-1:0] col_s;
  logic            col_any;
  logic [CW-1:0]   col_idx;

  assign clk_cut_d = kb.clk_cut;
  assign tick      = kb.clk_cut & ~clk_cut_q;
  assign col_s     = sync_q[SYNC_STAGES-1];
  assign col_any   = ~&col_s;

  // Lowest active (low) column wins when several are pressed.
  always_comb begin
    col_idx = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (!col_s[c]) col_idx = CW'(c);
  end

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    return (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    rec_row_d  = rec_row_q;
    rec_col_d  = rec_col_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    key_code_d = key_code_q;
    valid_d    = 1'b0;
    sync_d[0]  = kb.col_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    unique case (state_q)
      SCAN: if (tick && kb.enable_input) begin
        if (col_any) begin
          rec_row_d = row_idx_q;
          rec_col_d = col_idx;
          cnt_d     = NW'(1);
          state_d   = (STABLE_SAMPLES == 1) ? ACCEPT : CONFIRM;
        end else begin
          row_idx_d = next_row(row_idx_q);
        end
      end
      CONFIRM: if (tick && kb.enable_input) begin
        if (col_any && col_idx == rec_col_q) begin
          cnt_d = cnt_q + NW'(1);
          if (cnt_q + NW'(1) == NW'(STABLE_SAMPLES)) state_d = ACCEPT;
        end else begin
          cnt_d     = '0;
          row_idx_d = next_row(row_idx_q);
          state_d   = SCAN;
        end
      end
      ACCEPT: begin
        code_d  = KW'(int'(rec_row_q) * COLS + int'(rec_col_q));
        state_d = HOLD;
      end
      HOLD: begin
        // Publish reads code_q, so a simultaneous clear still emits the old code.
        if (kb.mostrar_dato) begin
          key_code_d = code_q;
          valid_d    = 1'b1;
          state_d    = RELEASE;
        end
        if (kb.reset_input_ff) begin
          code_d = '0;
          cnt_d  = '0;
          sync_d = '1;
        end
      end
      RELEASE: if (kb.enable_input && tick && !col_any) begin
        row_idx_d = '0;
        state_d   = SCAN;
      end
      default: state_d = SCAN;
    endcase

    if (kb.reset_input_ff && state_q != HOLD) begin
      sync_d = '1;
      cnt_d  = '0;
    end

    stop_d             = (state_d == ACCEPT);
    row_out_d          = '1;
    row_out_d[row_idx_d] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SCAN;
      row_idx_q  <= '0;
      rec_row_q  <= '0;
      rec_col_q  <= '0;
      cnt_q      <= '0;
      code_q     <= '0;
      key_code_q <= '0;
      sync_q     <= '1;
      row_out_q  <= ~ROWS'(1);
      stop_q     <= 1'b0;
      valid_q    <= 1'b0;
      clk_cut_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      rec_row_q  <= rec_row_d;
      rec_col_q  <= rec_col_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      key_code_q <= key_code_d;
      sync_q     <= sync_d;
      row_out_q  <= row_out_d;
      stop_q     <= stop_d;
      valid_q    <= valid_d;
      clk_cut_q  <= clk_cut_d;
    end
  end

  assign kb.row_out   = row_out_q;
  assign kb.stop_flag = stop_q;
  assign kb.key_code  = key_code_q;
  assign kb.key_valid = valid_q;
endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Scenario bench for keypad_scan_decoder: a switch-matrix keypad model drives
// the columns and published codes are checked against a queue of expected keys.
module tb_keypad_scan_decoder;
  logic clk;
  logic reset;

  keypad_scan_decoder_if #(.ROWS(4), .COLS(4)) kb_if ();

  keypad_scan_decoder #(
    .ROWS(4), .COLS(4), .SYNC_STAGES(2), .STABLE_SAMPLES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kb    (kb_if)
  );

  int total = 0;
  int bad   = 0;
  int stop_cnt  = 0;
  int valid_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0][3:0] keys;
  logic tick_stop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pressed switch (r,c) pulls column c low while row r is driven low.
  always_comb begin
    kb_if.col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !kb_if.row_out[r]) kb_if.col_in[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (kb_if.stop_flag === 1'b1) stop_cnt++;
    if (kb_if.key_valid === 1'b1) valid_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_tick();
    repeat (4) @(negedge clk);
    kb_if.clk_cut = 1'b1;
    @(negedge clk);
    tick_stop = kb_if.stop_flag;
    kb_if.clk_cut = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_until_stop(input int max, input string name);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      do_tick();
      seen = tick_stop;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_stop: stop_flag not seen within %0d ticks", name, max);
    end
  endtask

  task automatic check_row(input string name, input logic [3:0] exp);
    total++;
    if (kb_if.row_out !== exp) begin
      bad++;
      $display("FAIL %s: row_out=%b expected %b", name, kb_if.row_out, exp);
    end
  endtask

  task automatic check_code(input string name, input logic [3:0] exp);
    total++;
    if (kb_if.key_code !== exp) begin
      bad++;
      $display("FAIL %s: key_code=%0d expected %0d", name, kb_if.key_code, exp);
    end
  endtask

  // Pulse mostrar_dato (optionally with reset_input_ff) and score the publish.
  task automatic publish(input bit rff, input string name);
    bit got = 0;
    logic [3:0] exp;
    @(negedge clk);
    kb_if.mostrar_dato   = 1'b1;
    kb_if.reset_input_ff = rff;
    @(negedge clk);
    kb_if.mostrar_dato   = 1'b0;
    kb_if.reset_input_ff = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (kb_if.key_valid === 1'b1) got = 1;
      else @(negedge clk);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: publish with empty scoreboard, key_code=%0d", name, kb_if.key_code);
    end else begin
      exp = exp_q.pop_front();
      if (!got) begin
        bad++;
        $display("FAIL %s_valid: key_valid not seen, expected code %0d", name, exp);
      end else if (kb_if.key_code !== exp) begin
        bad++;
        $display("FAIL %s_code: key_code=%0d expected %0d", name, kb_if.key_code, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic release_and_rearm(input string name);
    keys = '0;
    do_tick();
    check_row({name, "_rearm_row"}, 4'b1110);
  endtask

  task automatic test_reset();
    #12;
    check_row("reset_row", 4'b1110);
    total++; if (kb_if.stop_flag !== 1'b0) begin bad++; $display("FAIL reset_stop: stop_flag=%b expected 0", kb_if.stop_flag); end
    check_code("reset_code", 4'd0);
    total++; if (kb_if.key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: key_valid=%b expected 0", kb_if.key_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle_scan();
    int s0 = stop_cnt;
    logic [3:0] er;
    for (int i = 0; i < 12; i++) begin
      er = ~(4'b0001 << (i % 4));
      check_row($sformatf("idle_row_%0d", i), er);
      do_tick();
    end
    check_row("idle_wrap_row", 4'b1110);
    total++; if (stop_cnt != s0) begin bad++; $display("FAIL idle_stop: stop pulses=%0d expected 0", stop_cnt - s0); end
  endtask

  task automatic test_press_decode();
    int s0 = stop_cnt;
    int v0;
    keys[2][1] = 1'b1;
    exp_q.push_back(4'd9);
    tick_until_stop(10, "press");
    check_row("press_hold_row", 4'b1011);
    do_tick(); do_tick();
    check_row("press_hold_row2", 4'b1011);
    total++; if (stop_cnt - s0 != 1) begin bad++; $display("FAIL press_stop_count: pulses=%0d expected 1", stop_cnt - s0); end
    v0 = valid_cnt;
    publish(1'b1, "press");
    check_code("press_code_after", 4'd9);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL press_valid_count: pulses=%0d expected 1", valid_cnt - v0); end
    release_and_rearm("press");
  endtask

  task automatic test_bounce();
    int s0 = stop_cnt;
    keys[0][2] = 1'b1;
    do_tick();
    check_row("bounce_confirm_row", 4'b1110);
    keys = '0;
    do_tick();
    check_row("bounce_next_row", 4'b1101);
    total++; if (stop_cnt != s0) begin bad++; $display("FAIL bounce_stop: pulses=%0d expected 0", stop_cnt - s0); end
  endtask

  task automatic test_held_key();
    int s0;
    keys[1][3] = 1'b1;
    exp_q.push_back(4'd7);
    tick_until_stop(6, "held");
    s0 = stop_cnt;
    kb_if.enable_input = 1'b0;
    publish(1'b0, "held");
    repeat (3) do_tick();
    kb_if.enable_input = 1'b1;
    repeat (3) do_tick();
    check_row("held_row", 4'b1101);
    total++; if (stop_cnt != s0) begin bad++; $display("FAIL held_second_stop: pulses=%0d expected 0", stop_cnt - s0); end
    release_and_rearm("held");
    keys[3][0] = 1'b1;
    exp_q.push_back(4'd12);
    tick_until_stop(10, "held_new");
    publish(1'b0, "held_new");
    release_and_rearm("held_new");
  endtask

  task automatic test_multi_col();
    keys[1][0] = 1'b1;
    keys[1][3] = 1'b1;
    exp_q.push_back(4'd4);
    tick_until_stop(10, "multi");
    publish(1'b0, "multi");
    release_and_rearm("multi");
  endtask

  task automatic test_outside_hold();
    int v0 = valid_cnt;
    @(negedge clk); kb_if.mostrar_dato = 1'b1;
    @(negedge clk); kb_if.mostrar_dato = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (valid_cnt != v0) begin bad++; $display("FAIL outside_valid: pulses=%0d expected 0", valid_cnt - v0); end
    check_code("outside_code", 4'd4);
    @(negedge clk); kb_if.reset_input_ff = 1'b1;
    @(negedge clk); kb_if.reset_input_ff = 1'b0;
    check_row("outside_rff_row", 4'b1110);
    check_code("outside_rff_code", 4'd4);
    do_tick();
    check_row("outside_rff_advance", 4'b1101);
    do_tick(); do_tick(); do_tick();
  endtask

  task automatic test_reset_in_hold();
    int v0;
    keys[2][2] = 1'b1;
    tick_until_stop(10, "rst_hold");
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_row("rst_hold_row", 4'b1110);
    check_code("rst_hold_code", 4'd0);
    total++; if (kb_if.stop_flag !== 1'b0) begin bad++; $display("FAIL rst_hold_stop: stop_flag=%b expected 0", kb_if.stop_flag); end
    total++; if (kb_if.key_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid: key_valid=%b expected 0", kb_if.key_valid); end
    @(negedge clk); reset = 1'b0;
    v0 = valid_cnt;
    @(negedge clk); kb_if.mostrar_dato = 1'b1;
    @(negedge clk); kb_if.mostrar_dato = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (valid_cnt != v0) begin bad++; $display("FAIL rst_hold_publish: pulses=%0d expected 0", valid_cnt - v0); end
    check_code("rst_hold_code_after", 4'd0);
    keys = '0;
  endtask

  initial begin
    reset = 1'b1;
    keys = '0;
    tick_stop = 1'b0;
    kb_if.clk_cut        = 1'b0;
    kb_if.enable_input   = 1'b1;
    kb_if.mostrar_dato   = 1'b0;
    kb_if.reset_input_ff = 1'b0;
    test_reset();
    test_idle_scan();
    test_press_decode();
    test_bounce();
    test_held_key();
    test_multi_col();
    test_outside_hold();
    test_reset_in_hold();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d expected codes never published", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
